simple_processor_top: RTL and testbench

//  - 9-bit multicycle processor top with eight GPRs (R0..R7), accumulator A, result G, IR and control FSM.
//  - Instructions and immediates arrive on DIN; all inter-register transfers go over one shared 9-bit Bus.
//  - The Bus is exported for observation. Done flags the last cycle of each instruction.

---
 rtl/simple_processor_top.sv | 149 ++++++++++++++
 tb/tb_simple_processor_top.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/simple_processor_top.sv
// 9-bit multicycle processor: eight GPRs, accumulator A, result G, IR and a T0..T3 control FSM on one shared bus.
// Define SIMPLE_PROC_SUB_EN to enable opcode 010 (sub); otherwise it decodes as NOP and the ALU is add-only.
module simple_processor_top #(
    parameter int unsigned DATA_W = 9
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    output logic [DATA_W-1:0] Bus,
    output logic              Done
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] g_q, g_d;
    logic [DATA_W-1:0] r_q [8];
    logic [DATA_W-1:0] r_d [8];

    logic [2:0]        op, rx, ry;
    logic              is_mv, is_add, is_sub, is_mvi;
    logic [7:0]        sel_r;
    logic              sel_g, sel_din;
    logic              ir_we, a_we, g_we, r_we;
    logic [DATA_W-1:0] alu;

    always_comb begin
        op     = ir_q[8:6];
        rx     = ir_q[5:3];
        ry     = ir_q[2:0];
        is_mv  = (op == 3'b000);
        is_add = (op == 3'b001);
        is_mvi = (op == 3'b011);
`ifdef SIMPLE_PROC_SUB_EN
        is_sub = (op == 3'b010);
`else
        is_sub = 1'b0;
`endif
    end

    // Control: one-hot bus source selects, write enables and next state.
    always_comb begin
        state_d = state_q;
        sel_r   = '0;
        sel_g   = 1'b0;
        sel_din = 1'b0;
        ir_we   = 1'b0;
        a_we    = 1'b0;
        g_we    = 1'b0;
        r_we    = 1'b0;
        Done    = 1'b0;
        case (state_q)
            T0: begin
                if (Run) begin
                    ir_we   = 1'b1;
                    state_d = T1;
                end
            end
            T1: begin
                if (is_mv) begin
                    sel_r[ry] = 1'b1;
                    r_we      = 1'b1;
                    Done      = 1'b1;
                    state_d   = T0;
                end else if (is_mvi) begin
                    sel_din = 1'b1;
                    r_we    = 1'b1;
                    Done    = 1'b1;
                    state_d = T0;
                end else if (is_add || is_sub) begin
                    sel_r[rx] = 1'b1;
                    a_we      = 1'b1;
                    state_d   = T2;
                end else begin
                    Done    = 1'b1;
                    state_d = T0;
                end
            end
            T2: begin
                sel_r[ry] = 1'b1;
                g_we      = 1'b1;
                state_d   = T3;
            end
            T3: begin
                sel_g   = 1'b1;
                r_we    = 1'b1;
                Done    = 1'b1;
                state_d = T0;
            end
            default: state_d = T0;
        endcase
    end

    always_comb begin
        Bus = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (sel_r[i]) Bus = Bus | r_q[i];
        end
        if (sel_g)   Bus = Bus | g_q;
        if (sel_din) Bus = Bus | DIN;
    end

    always_comb begin
`ifdef SIMPLE_PROC_SUB_EN
        alu = is_sub ? (a_q - Bus) : (a_q + Bus);
`else
        alu = a_q + Bus;
`endif
    end

    always_comb begin
        ir_d = ir_we ? DIN : ir_q;
        a_d  = a_we ? Bus : a_q;
        g_d  = g_we ? alu : g_q;
        for (int unsigned i = 0; i < 8; i++) begin
            r_d[i] = r_q[i];
        end
        if (r_we) r_d[rx] = Bus;
    end

    always_ff @(posedge Clock) begin
        if (Resetn) begin
            state_q <= T0;
            ir_q    <= '0;
            a_q     <= '0;
            g_q     <= '0;
            for (int unsigned i = 0; i < 8; i++) begin
                r_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            g_q     <= g_d;
            for (int unsigned i = 0; i < 8; i++) begin
                r_q[i] <= r_d[i];
            end
        end
    end

endmodule

// File: tb/tb_simple_processor_top.sv
// Bench for simple_processor_top: directed program, random instruction stream and mid-instruction reset,
// checked cycle by cycle against an instruction-level register model (honours SIMPLE_PROC_SUB_EN).
module tb_simple_processor_top;

    logic       clk;
    logic       resetn;
    logic       run;
    logic [8:0] din;
    logic [8:0] bus;
    logic       done;

    int errors = 0;
    int checks = 0;

    logic [8:0] model_r [8];

    simple_processor_top #(.DATA_W(9)) dut (
        .Clock  (clk),
        .Resetn (resetn),
        .Run    (run),
        .DIN    (din),
        .Bus    (bus),
        .Done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge with the FSM in T0; returns at a negedge with the FSM back in T0.
    task automatic exec(input logic [8:0] instr, input logic [8:0] imm);
        logic [2:0] op, x, y;
        logic [8:0] eb[$];
        bit         ed[$];
        logic [8:0] res;
        logic [31:0] rnd;
        op = instr[8:6];
        x  = instr[5:3];
        y  = instr[2:0];
        case (op)
            3'b000: begin eb = '{model_r[y]}; ed = '{1'b1}; end
            3'b011: begin eb = '{imm}; ed = '{1'b1}; end
            3'b001: begin
                res = model_r[x] + model_r[y];
                eb = '{model_r[x], model_r[y], res};
                ed = '{1'b0, 1'b0, 1'b1};
            end
`ifdef SIMPLE_PROC_SUB_EN
            3'b010: begin
                res = model_r[x] - model_r[y];
                eb = '{model_r[x], model_r[y], res};
                ed = '{1'b0, 1'b0, 1'b1};
            end
`endif
            default: begin eb = '{9'h000}; ed = '{1'b1}; end
        endcase

        run = 1'b1;
        din = instr;
        #1;
        check("t0_bus", bus, 9'h000);
        check("t0_done", {8'h00, done}, 9'h000);
        next_cycle();
        for (int k = 0; k < eb.size(); k++) begin
            rnd = $urandom;
            run = rnd[31];
            din = (k == 0) ? imm : rnd[8:0];
            #1;
            check($sformatf("bus_%h_step%0d", instr, k + 1), bus, eb[k]);
            check($sformatf("done_%h_step%0d", instr, k + 1), {8'h00, done}, {8'h00, ed[k]});
            next_cycle();
        end

        case (op)
            3'b000: model_r[x] = model_r[y];
            3'b011: model_r[x] = imm;
            3'b001: model_r[x] = res;
`ifdef SIMPLE_PROC_SUB_EN
            3'b010: model_r[x] = res;
`endif
            default: ;
        endcase
    endtask

    task automatic idle(input int n);
        logic [31:0] rnd;
        run = 1'b0;
        for (int k = 0; k < n; k++) begin
            rnd = $urandom;
            din = rnd[8:0];
            #1;
            check("idle_bus", bus, 9'h000);
            check("idle_done", {8'h00, done}, 9'h000);
            next_cycle();
        end
    endtask

    task automatic readout_all();
        for (int k = 0; k < 8; k++) begin
            exec({3'b000, k[2:0], k[2:0]}, 9'h000);
        end
    endtask

    initial begin
        logic [31:0] rnd;
        for (int k = 0; k < 8; k++) model_r[k] = 9'h000;
        resetn = 1'b1;
        run    = 1'b1;
        din    = 9'b001_000_001;
        repeat (2) @(posedge clk);
        @(negedge clk);
        run = 1'b0;
        #1;
        check("reset_bus", bus, 9'h000);
        check("reset_done", {8'h00, done}, 9'h000);
        resetn = 1'b0;
        next_cycle();
        readout_all();

        exec(9'b011_000_001, 9'b100_001_111);
        exec(9'b011_010_001, 9'b111_110_000);
        exec(9'b001_000_010, 9'h000);
        exec(9'b010_000_010, 9'h000);
        exec(9'b000_001_000, 9'h000);
        exec(9'b001_011_011, 9'h000);
        idle(3);
        readout_all();

        for (int n = 0; n < 60; n++) begin
            logic [8:0] ins, imm;
            rnd = $urandom;
            ins = rnd[8:0];
            imm = rnd[17:9];
            exec(ins, imm);
            if (rnd[31:29] == 3'b000) idle(1 + int'(rnd[28:27]));
        end
        readout_all();

        // Reset while in T2 of add R0,R2: abort, no write, all state cleared.
        exec(9'b011_000_101, 9'h055);
        run = 1'b1;
        din = 9'b001_000_010;
        next_cycle();
        run = 1'b0;
        next_cycle();
        #1;
        check("abort_t2_bus", bus, model_r[2]);
        check("abort_t2_done", {8'h00, done}, 9'h000);
        resetn = 1'b1;
        next_cycle();
        resetn = 1'b0;
        for (int k = 0; k < 8; k++) model_r[k] = 9'h000;
        #1;
        check("post_reset_bus", bus, 9'h000);
        check("post_reset_done", {8'h00, done}, 9'h000);
        next_cycle();
        readout_all();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
